// File: rtl/pwm_multi.sv
// Multi-channel double-buffered PWM generator.
// A single period counter (edge or center aligned) feeds CHANNELS duty
// comparators. Period, duty and mode are written into shadow registers
// and copied to the active set at the period boundary, or on every cycle
// while disabled.

// One PWM channel: duty shadow/active pair plus its comparator.
module pwm_multi_lane #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_i,
    input  logic             commit_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [WIDTH-1:0] cont_i,
    output logic             out_o
);
    logic [WIDTH-1:0] sh_q, sh_d, act_q, act_d;

    // Shadow takes the last write; active picks up the pre-edge shadow on commit.
    always_comb begin
        sh_d  = wr_i ? wr_data_i : sh_q;
        act_d = commit_i ? sh_q : act_q;
    end

    // Duty registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            sh_q  <= '0;
            act_q <= '0;
        end else begin
            sh_q  <= sh_d;
            act_q <= act_d;
        end
    end

    assign out_o = en_i && (cont_i < act_q);
endmodule

module pwm_multi #(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    localparam int AW       = $clog2(CHANNELS + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                io_en,
    input  logic                io_wr_valid,
    input  logic [AW-1:0]       io_wr_addr,
    input  logic [WIDTH-1:0]    io_wr_data,
    input  logic                io_mode,
    output logic [CHANNELS-1:0] io_out,
    output logic [WIDTH-1:0]    io_cont,
    output logic                io_period_end,
    output logic                io_pending
);
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             dn_q, dn_d;
    logic [WIDTH-1:0] per_q, per_d, per_sh_q, per_sh_d;
    logic             mode_q, mode_d, mode_sh_q, mode_sh_d;
    logic             pend_q, pend_d;
    logic             wr_ok, wr_per, period_last, commit;

    assign wr_ok  = io_wr_valid && (io_wr_addr <= AW'(CHANNELS));
    assign wr_per = io_wr_valid && (io_wr_addr == AW'(CHANNELS));

    // Last cycle of a period; T==0 makes every cycle both first and last.
    assign period_last = (per_q == '0) ||
                         (mode_q ? (dn_q && cnt_q == WIDTH'(1)) : (cnt_q == per_q));
    // While disabled the active set tracks the shadows continuously.
    assign commit = !io_en || period_last;

    // Counter/direction, shadow and commit next-state.
    always_comb begin
        cnt_d     = cnt_q;
        dn_d      = dn_q;
        per_sh_d  = wr_per ? io_wr_data : per_sh_q;
        mode_sh_d = wr_ok ? io_mode : mode_sh_q;
        per_d     = commit ? per_sh_q : per_q;
        mode_d    = commit ? mode_sh_q : mode_q;
        // A write landing on the commit edge keeps pending set.
        pend_d    = commit ? wr_ok : (pend_q || wr_ok);
        if (commit) begin
            cnt_d = '0;
            dn_d  = 1'b0;
        end else if (!mode_q) begin
            cnt_d = cnt_q + WIDTH'(1);
        end else if (dn_q) begin
            cnt_d = cnt_q - WIDTH'(1);
        end else begin
            cnt_d = cnt_q + WIDTH'(1);
            dn_d  = ((cnt_q + WIDTH'(1)) == per_q);
        end
    end

    // Shared counter, period/mode registers and pending flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q     <= '0;
            dn_q      <= 1'b0;
            per_q     <= '1;
            per_sh_q  <= '1;
            mode_q    <= 1'b0;
            mode_sh_q <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            dn_q      <= dn_d;
            per_q     <= per_d;
            per_sh_q  <= per_sh_d;
            mode_q    <= mode_d;
            mode_sh_q <= mode_sh_d;
            pend_q    <= pend_d;
        end
    end

    for (genvar n = 0; n < CHANNELS; n++) begin : g_lane
        pwm_multi_lane #(.WIDTH(WIDTH)) u_lane (
            .clock     (clock),
            .reset     (reset),
            .wr_i      (io_wr_valid && (io_wr_addr == AW'(n))),
            .commit_i  (commit),
            .en_i      (io_en),
            .wr_data_i (io_wr_data),
            .cont_i    (cnt_q),
            .out_o     (io_out[n])
        );
    end

    assign io_cont       = cnt_q;
    assign io_period_end = io_en && (cnt_q == '0) && !dn_q;
    assign io_pending    = pend_q;
endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi (WIDTH=8, CHANNELS=4): per-cycle expectations are
// queued when inputs are driven and compared on the falling edge.
module tb_pwm_multi;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       io_en = 1'b0;
    logic       io_wr_valid = 1'b0;
    logic [2:0] io_wr_addr = '0;
    logic [7:0] io_wr_data = '0;
    logic       io_mode = 1'b0;
    logic [3:0] io_out;
    logic [7:0] io_cont;
    logic       io_period_end;
    logic       io_pending;

    pwm_multi #(.WIDTH(8), .CHANNELS(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .io_en         (io_en),
        .io_wr_valid   (io_wr_valid),
        .io_wr_addr    (io_wr_addr),
        .io_wr_data    (io_wr_data),
        .io_mode       (io_mode),
        .io_out        (io_out),
        .io_cont       (io_cont),
        .io_period_end (io_period_end),
        .io_pending    (io_pending)
    );

    always #5 clock = ~clock;

    typedef struct {
        string      tag;
        logic [7:0] cont;
        logic [3:0] out;
        logic [3:0] om;   // which out bits to check
        logic       pe;
        logic       pend;
        logic [2:0] m;    // check {cont, period_end, pending}
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input string tag, input int cont, input int out, input int om,
                                input bit pe, input bit pend, input int m);
        exp_t e;
        e.tag = tag; e.cont = 8'(cont); e.out = 4'(out); e.om = 4'(om);
        e.pe = pe; e.pend = pend; e.m = 3'(m);
        return e;
    endfunction

    function automatic exp_t none();
        return mk("none", 0, 0, 0, 0, 0, 0);
    endfunction

    always @(negedge clock) begin
        if (sbq.size() != 0) begin
            exp_t e;
            e = sbq.pop_front();
            if (e.m[2]) chk({e.tag, ".cont"}, 32'(io_cont), 32'(e.cont));
            if (e.om != 0) chk({e.tag, ".out"}, 32'(io_out & e.om), 32'(e.out & e.om));
            if (e.m[1]) chk({e.tag, ".pe"}, 32'(io_period_end), 32'(e.pe));
            if (e.m[0]) chk({e.tag, ".pend"}, 32'(io_pending), 32'(e.pend));
        end
    end

    task automatic cyc(input bit rst, input bit en, input bit wv, input int wa, input int wd,
                       input bit md, input exp_t e);
        @(posedge clock);
        #1;
        reset = rst; io_en = en; io_wr_valid = wv;
        io_wr_addr = 3'(wa); io_wr_data = 8'(wd); io_mode = md;
        sbq.push_back(e);
    endtask

    // Disable, write period and all duties, then one settling idle cycle.
    task automatic load_all(input int per, input int d0, input int d1, input int d2,
                            input int d3, input bit md);
        cyc(0, 0, 0, 0, 0, md, none());
        cyc(0, 0, 1, 4, per, md, mk("ld_per", 0, 0, 15, 0, 0, 7));
        cyc(0, 0, 1, 0, d0, md, mk("ld_d0", 0, 0, 15, 0, 1, 7));
        cyc(0, 0, 1, 1, d1, md, mk("ld_d1", 0, 0, 15, 0, 1, 7));
        cyc(0, 0, 1, 2, d2, md, mk("ld_d2", 0, 0, 15, 0, 1, 7));
        cyc(0, 0, 1, 3, d3, md, mk("ld_d3", 0, 0, 15, 0, 1, 7));
        cyc(0, 0, 0, 0, 0, md, mk("ld_idle", 0, 0, 15, 0, 1, 7));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] p0, p1, p2, p3;
        logic [5:0] cpat;
        int         cseq[6];
        int         o;
        // Reset state
        cyc(1, 0, 0, 0, 0, 0, mk("rst", 0, 0, 15, 0, 0, 7));
        cyc(0, 0, 0, 0, 0, 0, mk("rst_rel", 0, 0, 15, 0, 0, 7));

        // Edge mode T=4, duties 0,2,4,9
        load_all(4, 0, 2, 4, 9, 0);
        p0 = 5'b00000; p1 = 5'b11000; p2 = 5'b11110; p3 = 5'b11111;
        for (int i = 0; i < 10; i++) begin
            int c;
            c = i % 5;
            o = {p3[4-c], p2[4-c], p1[4-c], p0[4-c]};
            cyc(0, 1, 0, 0, 0, 0, mk("edge4", c, o, 15, c == 0, 0, 7));
        end

        // Center mode T=3, duty0=2
        load_all(3, 2, 2, 4, 9, 1);
        cpat = 6'b110001;
        cseq = '{0, 1, 2, 3, 2, 1};
        for (int i = 0; i < 12; i++) begin
            int k;
            k = i % 6;
            cyc(0, 1, 0, 0, 0, 1, mk("ctr3", cseq[k], 32'(cpat[5-k]), 1, k == 0, 0, 7));
        end

        // Edge T=9: mid-period write, then write on the commit edge
        load_all(9, 3, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            cyc(0, 1, i == 5, 0, 7, 0, mk("mid_p1", i, i < 3, 1, i == 0, i >= 6, 7));
        for (int i = 0; i < 10; i++)
            cyc(0, 1, i == 9, 0, 2, 0, mk("mid_p2", i, i < 7, 1, i == 0, 0, 7));
        for (int i = 0; i < 10; i++)
            cyc(0, 1, 0, 0, 0, 0, mk("cedge_p3", i, i < 7, 1, i == 0, 1, 7));
        for (int i = 0; i < 10; i++)
            cyc(0, 1, 0, 0, 0, 0, mk("cedge_p4", i, i < 2, 1, i == 0, 0, 7));

        // T=0: counter pinned at 0, every cycle a period start
        load_all(0, 1, 0, 4, 9, 0);
        for (int i = 0; i < 5; i++)
            cyc(0, 1, 0, 0, 0, 0, mk("t0", 0, 4'b1101, 15, 1, 0, 7));

        // Reset mid-period, then default period 255 runs
        load_all(9, 9, 9, 9, 9, 0);
        for (int i = 0; i < 7; i++)
            cyc(i == 6, 1, 0, 0, 0, 0, mk("pre_rst", i, 15, 15, i == 0, 0, 7));
        cyc(0, 1, 0, 0, 0, 0, mk("post_rst", 0, 0, 15, 1, 0, 7));
        for (int i = 1; i < 256; i++)
            cyc(0, 1, 0, 0, 0, 0, mk("per255", i, 0, 15, 0, 0, 7));
        cyc(0, 1, 0, 0, 0, 0, mk("per255_wrap", 0, 0, 15, 1, 0, 7));

        // Disabled: outputs low regardless of duty; invalid address ignored
        cyc(0, 0, 1, 0, 9, 0, mk("dis_wr", 0, 0, 15, 0, 0, 3'b010));
        cyc(0, 0, 1, 7, 55, 0, mk("dis_bad", 0, 0, 15, 0, 1, 3'b111));
        cyc(0, 0, 0, 0, 0, 0, mk("dis_idle", 0, 0, 15, 0, 0, 7));
        cyc(0, 1, 0, 0, 0, 0, mk("reen", 0, 4'b0001, 15, 1, 0, 7));

        @(negedge clock);
        #1;
        chk("sbq_drain", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
